// File: rtl/robo_copier.sv
// robo_copier: buffers one interleaved block of BLK_LEN bits, then replays it
// NCOPY times, each copy starting SHIFT bits further round the block
// (cyclically). Output stream is fully registered; buffer storage is not reset.
module robo_copier #(
  parameter int BLK_LEN = 128,
  parameter int NCOPY   = 4,
  parameter int SHIFT   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic din,
  input  logic din_vld,
  output logic request,
  output logic dout,
  output logic dout_vld,
  output logic dout_first,
  output logic busy,
  output logic done
);

  localparam int AW = $clog2(BLK_LEN);
  localparam int KW = (NCOPY > 1) ? $clog2(NCOPY) : 1;

  localparam logic [AW:0]   FILL_LEN = (AW+1)'(BLK_LEN);
  localparam logic [AW:0]   FILL_END = (AW+1)'(BLK_LEN - 1);
  localparam logic [AW-1:0] J_LAST   = AW'(BLK_LEN - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NCOPY - 1);
  localparam logic [AW-1:0] SHIFT_A  = AW'(SHIFT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_COPY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [AW:0]        wr_cnt_q, wr_cnt_d;
  logic [KW-1:0]      k_q, k_d;
  logic [AW-1:0]      j_q, j_d;
  // base_q holds k*SHIFT mod BLK_LEN so the read address is one add, no multiply
  logic [AW-1:0]      base_q, base_d;
  logic [BLK_LEN-1:0] mem_q, mem_d;
  logic               dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               dout_first_q, dout_first_d;
  logic               done_q, done_d;
  logic [AW-1:0]      rd_addr;

  // Read address wraps naturally by truncation to AW bits
  assign rd_addr = base_q + j_q;

  assign request    = (state_q == S_FILL) && (wr_cnt_q < FILL_LEN);
  assign busy       = (state_q != S_IDLE);
  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign dout_first = dout_first_q;
  assign done       = done_q;

  // Next-state, buffer write and output stream generation
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    k_d          = k_q;
    j_d          = j_q;
    base_d       = base_q;
    mem_d        = mem_q;
    dout_d       = 1'b0;
    dout_vld_d   = 1'b0;
    dout_first_d = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q high means we are in the pulse cycle right after DONE;
        // a start landing there must not launch a new block
        if (start && !done_q) begin
          state_d  = S_FILL;
          wr_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (din_vld && (wr_cnt_q < FILL_LEN)) begin
          mem_d[wr_cnt_q[AW-1:0]] = din;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == FILL_END) begin
            state_d = S_COPY;
            k_d     = '0;
            j_d     = '0;
            base_d  = '0;
          end
        end
      end
      S_COPY: begin
        dout_d       = mem_q[rd_addr];
        dout_vld_d   = 1'b1;
        dout_first_d = (j_q == '0);
        if (j_q == J_LAST) begin
          j_d    = '0;
          base_d = base_q + SHIFT_A;
          if (k_q == K_LAST) state_d = S_DONE;
          else               k_d = k_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        wr_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset dominates start and din_vld
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_cnt_q     <= '0;
      k_q          <= '0;
      j_q          <= '0;
      base_q       <= '0;
      dout_q       <= 1'b0;
      dout_vld_q   <= 1'b0;
      dout_first_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      k_q          <= k_d;
      j_q          <= j_d;
      base_q       <= base_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      dout_first_q <= dout_first_d;
      done_q       <= done_d;
    end
  end

  // Block storage; contents only matter after a complete refill
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_robo_copier.sv
// Bench for robo_copier (default parameters). Expected output stream is built
// from the filled bits with the cyclic-shift formula and drained by one
// compare process every cycle; a few literal index lists pin that model.
module tb_robo_copier;
  localparam int BLK = 128;
  localparam int NC  = 4;
  localparam int SH  = 32;

  logic clk = 1'b0;
  logic rst, start, din, din_vld;
  logic request, dout, dout_vld, dout_first, busy, done;

  int checks = 0;
  int errors = 0;

  robo_copier #(.BLK_LEN(BLK), .NCOPY(NC), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_vld(din_vld),
    .request(request), .dout(dout), .dout_vld(dout_vld),
    .dout_first(dout_first), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // model state: expected {bit, first} entries, plus logs for literal checks
  logic [1:0] exp_q[$];
  int         ones_q[$];
  int         firsts_q[$];
  logic       fbits_q[$];
  int         out_idx = 0;
  bit         started = 0;
  bit         pend_done = 0;
  bit         chk_en = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the expected stream
  always @(negedge clk) begin
    logic [1:0] e;
    logic       exp_done;
    if (chk_en) begin
      exp_done  = pend_done;
      pend_done = 0;
      chk("done", done, exp_done);
      if (dout_vld) begin
        if (exp_q.size() == 0) begin
          chk("spurious_vld", dout_vld, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", dout, e[1]);
          chk("dout_first", dout_first, e[0]);
          if (dout) ones_q.push_back(out_idx);
          if (dout_first) begin
            firsts_q.push_back(out_idx);
            fbits_q.push_back(dout);
          end
          out_idx++;
          started = 1;
          if (exp_q.size() == 0) begin
            pend_done = 1;
            started   = 0;
          end
        end
      end else begin
        chk("dout_idle", dout, 0);
        chk("first_idle", dout_first, 0);
        if (started) chk("vld_gap", dout_vld, 1);
      end
    end
  end

  // Start a block, load the expected stream, then feed data with optional gaps
  // between bits and optional extra valid bits beyond BLK
  task automatic do_fill(input logic [BLK-1:0] data, input int gap, input int extra);
    out_idx = 0;
    ones_q.delete(); firsts_q.delete(); fbits_q.delete();
    @(posedge clk); #1 start = 1;
    for (int k = 0; k < NC; k++)
      for (int j = 0; j < BLK; j++)
        exp_q.push_back({data[(k*SH + j) % BLK], (j == 0)});
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("req_after_start", request, 1);
    for (int n = 0; n < BLK + extra; n++) begin
      @(posedge clk); #1 din_vld = 1;
      din = (n < BLK) ? data[n] : 1'($urandom);
      @(negedge clk);
      chk("req_fill", request, (n < BLK));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1 din_vld = 0; din = ~din;
        @(negedge clk);
        chk("req_gap", request, (n < BLK - 1));
      end
    end
    @(posedge clk); #1 din_vld = 0; din = 0;
    @(negedge clk);
    chk("req_end", request, 0);
  endtask

  // Returns at the negedge of the done pulse, or flags a timeout
  task automatic wait_done();
    bit got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
    end
    chk("done_seen", got, 1);
    chk("busy_in_done_cycle", busy, 0);
    chk("stream_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BLK-1:0] d;
    int exp_ones[4]   = '{0, 224, 320, 416};
    int exp_firsts[4] = '{0, 128, 256, 384};

    // reset, with start/din_vld asserted to show reset wins
    rst = 1; start = 1; din = 1; din_vld = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_request", request, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_dout_first", dout_first, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 rst = 0; start = 0; din = 0; din_vld = 0;
    chk_en = 1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // single one at buf[0]
    d = '0; d[0] = 1'b1;
    do_fill(d, 0, 0);
    wait_done();
    chk("ones_cnt", ones_q.size(), 4);
    for (int i = 0; i < 4 && i < ones_q.size(); i++) chk("ones_idx", ones_q[i], exp_ones[i]);
    chk("firsts_cnt", firsts_q.size(), 4);
    for (int i = 0; i < 4 && i < firsts_q.size(); i++) chk("first_idx", firsts_q[i], exp_firsts[i]);

    // 1010... with din_vld one on, two off
    for (int n = 0; n < BLK; n++) d[n] = (n % 2 == 0);
    do_fill(d, 2, 0);
    wait_done();
    chk("alt_firsts_cnt", fbits_q.size(), 4);
    for (int i = 0; i < fbits_q.size(); i++) chk("alt_first_bit", fbits_q[i], 1);

    // 140 valid cycles: last 12 must be dropped
    for (int n = 0; n < BLK; n++) d[n] = 1'($urandom);
    do_fill(d, 0, 12);
    wait_done();

    // reset in the middle of the copy, then a clean block
    for (int n = 0; n < BLK; n++) d[n] = 1'($urandom);
    do_fill(d, 0, 0);
    for (int c = 0; c < 1000 && out_idx < 200; c++) @(negedge clk);
    chk("reached_idx200", (out_idx >= 200), 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    exp_q.delete(); started = 0; pend_done = 0;
    @(negedge clk);
    chk("midrst_dout", dout, 0);
    chk("midrst_dout_vld", dout_vld, 0);
    chk("midrst_dout_first", dout_first, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_request", request, 0);
    chk("midrst_done", done, 0);
    for (int n = 0; n < BLK; n++) d[n] = 1'($urandom);
    do_fill(d, 0, 0);
    wait_done();

    // start during COPY and in the done cycle must be ignored
    for (int n = 0; n < BLK; n++) d[n] = 1'($urandom);
    do_fill(d, 0, 0);
    repeat (50) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    wait_done();
    start = 1;
    @(posedge clk); #1 start = 0;
    repeat (6) begin
      @(negedge clk);
      chk("post_done_busy", busy, 0);
      chk("post_done_request", request, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
